// File: rtl/seg_scan_pkg.sv
// seg_scan_ctrl shared definitions.
// Digit count, select width and scan FSM states.
package seg_scan_pkg;

  localparam int SEG_DIGITS = 4;
  localparam int SEG_SEL_W  = 2;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// tick_gen: modulo counter with synchronous clear.
// Modulus picked per state: MOD_A when mod_sel=0, MOD_B otherwise.
module tick_gen #(
  parameter int W     = 2,
  parameter int MOD_A = 4,
  parameter int MOD_B = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic mod_sel,
  output logic tc
);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  // terminal count of the currently selected modulus
  always_comb begin
    last = mod_sel ? W'(MOD_B - 1) : W'(MOD_A - 1);
  end

  assign tc = (cnt == last);

  // count up, wrap to zero at terminal count or on clear
  always_ff @(posedge clk) begin
    if (clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit display scan with frame-synced mask update.
// Optional blanking gap after each digit: define SEG_SCAN_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV_MAX   = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] mask_in,
  input  logic       upd_req,
  output logic       upd_ack,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_done
);

`ifdef SEG_SCAN_BLANK_EN
  localparam int CNT_MAX =
    (DIV_MAX > BLANK_CYC) ? DIV_MAX : BLANK_CYC;
`else
  localparam int CNT_MAX = DIV_MAX;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);

  scan_state_t           state;
  logic [SEG_DIGITS-1:0] mask_sh;
  logic                  tc;
  logic                  adv;
  logic                  wrap;

  tick_gen #(
    .W     (CNT_W),
    .MOD_A (DIV_MAX),
    .MOD_B (BLANK_CYC)
  ) u_tick (
    .clk     (clk),
    .clr     (rst),
    .mod_sel (state == GAP),
    .tc      (tc)
  );

`ifdef SEG_SCAN_BLANK_EN
  assign adv = tc && (state == GAP);
`else
  assign adv = tc;
`endif

  assign wrap = adv && (sel == SEG_SEL_W'(SEG_DIGITS - 1));

  // scan FSM, digit select, shadow mask and handshake pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SHOW;
      sel        <= '0;
      mask_sh    <= '1;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      upd_ack    <= wrap && upd_req;
      if (wrap && upd_req) begin
        mask_sh <= mask_in;
      end
      if (adv) begin
        sel <= sel + 1'b1;
      end
`ifdef SEG_SCAN_BLANK_EN
      if (tc) begin
        state <= (state == SHOW) ? GAP : SHOW;
      end
`else
      state <= SHOW;
`endif
    end
  end

  // active-low anode for the selected digit, dark during GAP
  always_comb begin
    an = 4'b1111;
    if (state == SHOW) begin
      an[sel] = ~mask_sh[sel];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl.
// Expected values come from cycle index arithmetic.
module tb_seg_scan_ctrl;

  localparam int DIV  = 4;
  localparam int DIV2 = 2;
  localparam int BLK  = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int GAPL = BLK;
`else
  localparam int GAPL = 0;
`endif
  localparam int PER    = DIV + GAPL;
  localparam int PER2   = DIV2 + GAPL;
  localparam int FRAME  = 4 * PER;
  localparam int FRAME2 = 4 * PER2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mask_in = 4'b0000;
  logic       upd_req = 1'b0;
  logic       upd_ack;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame_done;

  logic [3:0] mask_in2 = 4'b0000;
  logic       upd_req2 = 1'b0;
  logic       ack2;
  logic [1:0] sel2;
  logic [3:0] an2;
  logic       fd2;

  int checks = 0;
  int fails  = 0;
  int t      = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV_MAX(DIV), .BLANK_CYC(BLK)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .mask_in    (mask_in),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .sel        (sel),
    .an         (an),
    .frame_done (frame_done)
  );

  seg_scan_ctrl #(.DIV_MAX(DIV2), .BLANK_CYC(BLK)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .mask_in    (mask_in2),
    .upd_req    (upd_req2),
    .upd_ack    (ack2),
    .sel        (sel2),
    .an         (an2),
    .frame_done (fd2)
  );

  function automatic logic [1:0] m_sel(int tt, int per);
    return 2'((tt / per) % 4);
  endfunction

  function automatic logic [3:0] m_an(int tt, int per, int div,
                                      logic [3:0] m);
    int d;
    logic [3:0] a;
    d = (tt / per) % 4;
    a = 4'b1111;
    if ((tt % per) < div && m[d]) a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic m_fd(int tt, int frame);
    return (tt > 0) && (tt % frame == 0);
  endfunction

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    upd_req = 1'b1;
    mask_in = 4'b0000;
    @(negedge clk);
    checks++;
    if ({sel, an, frame_done, upd_ack} !== {2'd0, 4'b1110, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_hold: got sel=%0d an=%b fd=%b ack=%b want 0 1110 0 0",
               sel, an, frame_done, upd_ack);
    end
    upd_req = 1'b0;
    do_reset();
    checks++;
    if ({sel, an, frame_done, upd_ack} !== {2'd0, 4'b1110, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_rel: got sel=%0d an=%b fd=%b ack=%b want 0 1110 0 0",
               sel, an, frame_done, upd_ack);
    end
  endtask

  task automatic test_scan();
    do_reset();
    while (t <= FRAME + PER + 1) begin
      checks++;
      if (sel !== m_sel(t, PER) || an !== m_an(t, PER, DIV, 4'b1111) ||
          frame_done !== m_fd(t, FRAME) || upd_ack !== 1'b0) begin
        fails++;
        $display("FAIL scan t=%0d: got sel=%0d an=%b fd=%b ack=%b want %0d %b %b 0",
                 t, sel, an, frame_done, upd_ack, m_sel(t, PER),
                 m_an(t, PER, DIV, 4'b1111), m_fd(t, FRAME));
      end
      step();
    end
  endtask

  task automatic test_mask_update();
    logic [3:0] m;
    do_reset();
    while (t <= 2 * FRAME + 1) begin
      m = (t >= FRAME) ? 4'b0101 : 4'b1111;
      checks++;
      if (sel !== m_sel(t, PER) || an !== m_an(t, PER, DIV, m) ||
          frame_done !== m_fd(t, FRAME) || upd_ack !== (t == FRAME)) begin
        fails++;
        $display("FAIL mask_upd t=%0d: got sel=%0d an=%b fd=%b ack=%b want %0d %b %b %b",
                 t, sel, an, frame_done, upd_ack, m_sel(t, PER),
                 m_an(t, PER, DIV, m), m_fd(t, FRAME), (t == FRAME));
      end
      if (t == 6) begin
        upd_req = 1'b1;
        mask_in = 4'b0101;
      end
      if (upd_ack) upd_req = 1'b0;
      step();
    end
    upd_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    while (t < 2 * PER + 1) step();
    upd_req = 1'b1;
    mask_in = 4'b0100;
    step();
    checks++;
    if (sel !== 2'd2 || upd_ack !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_pre: got sel=%0d ack=%b want 2 0", sel, upd_ack);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    upd_req = 1'b0;
    t = 0;
    checks++;
    if (sel !== 2'd0 || an !== 4'b1110 || upd_ack !== 1'b0 ||
        frame_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: got sel=%0d an=%b ack=%b fd=%b want 0 1110 0 0",
               sel, an, upd_ack, frame_done);
    end
    while (t <= FRAME + 1) begin
      checks++;
      if (sel !== m_sel(t, PER) || an !== m_an(t, PER, DIV, 4'b1111) ||
          frame_done !== m_fd(t, FRAME) || upd_ack !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid_run t=%0d: got sel=%0d an=%b fd=%b ack=%b want %0d %b %b 0",
                 t, sel, an, frame_done, upd_ack, m_sel(t, PER),
                 m_an(t, PER, DIV, 4'b1111), m_fd(t, FRAME));
      end
      step();
    end
    while (t < 2 * FRAME - 1) step();
    upd_req = 1'b1;
    mask_in = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    upd_req = 1'b0;
    t = 0;
    checks++;
    if (frame_done !== 1'b0 || upd_ack !== 1'b0 || an !== 4'b1110 ||
        sel !== 2'd0) begin
      fails++;
      $display("FAIL rst_at_wrap: got fd=%b ack=%b an=%b sel=%0d want 0 0 1110 0",
               frame_done, upd_ack, an, sel);
    end
  endtask

  task automatic test_same_cycle_req();
    do_reset();
    while (t < FRAME - 1) step();
    checks++;
    if (upd_ack !== 1'b0 || sel !== 2'd3) begin
      fails++;
      $display("FAIL same_pre: got ack=%b sel=%0d want 0 3", upd_ack, sel);
    end
    upd_req = 1'b1;
    mask_in = 4'b1010;
    step();
    checks++;
    if (upd_ack !== 1'b1 || frame_done !== 1'b1 || sel !== 2'd0 ||
        an !== 4'b1111) begin
      fails++;
      $display("FAIL same_wrap: got ack=%b fd=%b sel=%0d an=%b want 1 1 0 1111",
               upd_ack, frame_done, sel, an);
    end
    upd_req = 1'b0;
    step();
    checks++;
    if (upd_ack !== 1'b0 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL same_pulse: got ack=%b fd=%b want 0 0", upd_ack, frame_done);
    end
    while (t < FRAME + PER) step();
    checks++;
    if (sel !== 2'd1 || an !== 4'b1101) begin
      fails++;
      $display("FAIL same_dig1: got sel=%0d an=%b want 1 1101", sel, an);
    end
  endtask

  task automatic test_back_to_back();
    logic prev_fd;
    do_reset();
    prev_fd = 1'b0;
    while (t <= 2 * FRAME2 + 2) begin
      checks++;
      if (sel2 !== m_sel(t, PER2) || an2 !== m_an(t, PER2, DIV2, 4'b1111) ||
          fd2 !== m_fd(t, FRAME2) || ack2 !== 1'b0 || (prev_fd && fd2)) begin
        fails++;
        $display("FAIL div2 t=%0d: got sel=%0d an=%b fd=%b ack=%b want %0d %b %b 0",
                 t, sel2, an2, fd2, ack2, m_sel(t, PER2),
                 m_an(t, PER2, DIV2, 4'b1111), m_fd(t, FRAME2));
      end
      prev_fd = fd2;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mask_update();
    test_reset_mid();
    test_same_cycle_req();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
